// File: rtl/spike_aer_if.sv
// AER event stream between the spike encoder and the inter-core router.
//   aer_valid_o  event valid (encoder -> router)
//   aer_ready_i  router accepts the event (router -> encoder)
//   aer_addr_o   neuron index of the event
//   aer_core_o   originating core id
//   aer_last_o   final event of the frame
// Modports: master = encoder side, slave = router side.
interface spike_aer_if #(
  parameter int ADDR_W = 8
);
  logic              aer_valid_o;
  logic              aer_ready_i;
  logic [ADDR_W-1:0] aer_addr_o;
  logic              aer_core_o;
  logic              aer_last_o;

  modport master (
    output aer_valid_o,
    output aer_addr_o,
    output aer_core_o,
    output aer_last_o,
    input  aer_ready_i
  );

  modport slave (
    input  aer_valid_o,
    input  aer_addr_o,
    input  aer_core_o,
    input  aer_last_o,
    output aer_ready_i
  );
endinterface

// File: rtl/spike_aer_encoder.sv
// Spike-vector to AER event encoder.
// Snapshots a core's spike vector on spike_valid_i and emits one event per
// set bit, lowest neuron index first, over a valid/ready stream.
// Ports:
//   wb_clk_i, wb_rst_i  clock, synchronous active-high reset
//   spike_valid_i       strobe: spike_vec_i holds a complete timestep result
//   spike_vec_i         spike vector, neuron n = spike_vec_i[NUM_NEURONS-1-n]
//   busy_o              frame captured and not yet fully emitted
//   frame_done_o        one-cycle pulse when a frame completes
//   spike_count_o       events in the last completed frame
//   overflow_o          sticky: a frame was dropped; cleared by clr_ovf_i
//   aer                 event stream (master side of spike_aer_if)
//   aer_ts_o            timestep stamp of the current frame
//                       (only with SPIKE_AER_TIMESTAMP_EN defined)
// Optional feature macro: SPIKE_AER_TIMESTAMP_EN
module spike_aer_encoder #(
  parameter int   NUM_NEURONS = 256,
  parameter int   ADDR_W      = 8,
  parameter logic CORE_ID     = 1'b0
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   spike_valid_i,
  input  logic [NUM_NEURONS-1:0] spike_vec_i,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [ADDR_W:0]        spike_count_o,
  output logic                   overflow_o,
  input  logic                   clr_ovf_i,
`ifdef SPIKE_AER_TIMESTAMP_EN
  output logic [15:0]            aer_ts_o,
`endif
  spike_aer_if.master            aer
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t                 state;
  logic [NUM_NEURONS-1:0] mask;       // bit n = neuron n still pending
  logic [NUM_NEURONS-1:0] vec_rev;
  logic [NUM_NEURONS-1:0] mask_clr;
  logic [ADDR_W-1:0]      low_idx;
  logic [ADDR_W:0]        evt_cnt;
  logic                   valid_q;
  logic                   last_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   done_q;
  logic [ADDR_W:0]        count_q;
  logic                   ovf_q;
  logic                   drop;

`ifdef SPIKE_AER_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_q;
  assign aer_ts_o = ts_q;
`endif

  // Mask is stored neuron-indexed so the priority encode runs on bit n = neuron n.
  always_comb begin
    vec_rev = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      vec_rev[i] = spike_vec_i[NUM_NEURONS-1-i];
    end
  end

  // Scan from the top so the last hit (lowest index) wins.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      if (mask[NUM_NEURONS-1-i]) begin
        low_idx = ADDR_W'(NUM_NEURONS-1-i);
      end
    end
    mask_clr          = mask;
    mask_clr[low_idx] = 1'b0;
  end

  // The final-handshake cycle is still EMIT, so a strobe there is a drop.
  assign drop = spike_valid_i && (state != S_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      mask    <= '0;
      evt_cnt <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef SPIKE_AER_TIMESTAMP_EN
      ts_cnt  <= '0;
      ts_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;

      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf_i) begin
        ovf_q <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (spike_valid_i) begin
            mask    <= vec_rev;
            evt_cnt <= '0;
            state   <= S_LOAD;
`ifdef SPIKE_AER_TIMESTAMP_EN
            ts_q    <= ts_cnt;
            ts_cnt  <= ts_cnt + 16'd1;
`endif
          end
        end

        S_LOAD: begin
          if (mask == '0) begin
            done_q  <= 1'b1;
            count_q <= '0;
            state   <= S_IDLE;
          end else begin
            addr_q  <= low_idx;
            mask    <= mask_clr;
            valid_q <= 1'b1;
            last_q  <= (mask_clr == '0);
            evt_cnt <= evt_cnt + (ADDR_W+1)'(1);
            state   <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (valid_q && aer.aer_ready_i) begin
            if (!last_q) begin
              // Present the next event directly: no bubble between events.
              addr_q  <= low_idx;
              mask    <= mask_clr;
              last_q  <= (mask_clr == '0);
              evt_cnt <= evt_cnt + (ADDR_W+1)'(1);
            end else begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              count_q <= evt_cnt;
              state   <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = (state != S_IDLE);
  assign frame_done_o    = done_q;
  assign spike_count_o   = count_q;
  assign overflow_o      = ovf_q;
  assign aer.aer_valid_o = valid_q;
  assign aer.aer_addr_o  = addr_q;
  assign aer.aer_last_o  = last_q;
  assign aer.aer_core_o  = CORE_ID;

endmodule
